event_encoder_8x3: RTL and testbench
====================================

// Module: event_encoder_8x3
// PURPOSE
//   Return path for the 3x8 one-hot decoder: collects events on 8 request lines, holds them as
//   pending, and presents them one at a time as a 3-bit index with a valid/ready handshake.
//   Feeds a 3-bit consumer (e.g. a decoder or a counter bank) and guarantees no accepted event is
//   dropped. Overflow flags an event that lands on an already-pending line.
// PARAMETERS
//   N_IN       8   number of request lines (fixed at 8 for this revision)
//   CODE_W     3   width of code_out, equal to clog2(N_IN)
//   HIGH_FIRST 1   1: highest index wins; 0: lowest index wins
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   req_in       in   N_IN    event strobes; bit i high in any cycle = one event on line i
//   code_out     out  CODE_W  index of the presented event; 0 when valid_out=0
//   valid_out    out  1       code_out holds a pending event
//   ready_in     in   1       consumer accepts code_out this cycle
//   pending_out  out  N_IN    registered pending vector, including the presented bit
//   overflow_out out  1       one-cycle pulse: an event was merged into a pending bit
// BEHAVIOUR
//   Reset: pending=0, code_out=0, valid_out=0, overflow_out=0, state=EMPTY. The reset is async, so
//     assertion mid-operation drops all pending and presented events immediately.
//   accept = valid_out & ready_in.
//   Pending update at each edge:
//     pending_nxt = (pending & ~(accept ? onehot(code_out) : 0)) | req_in
//   FSM states and transitions:
//     EMPTY: valid_out=0. If pending_nxt != 0, load code_out = pick(pending_nxt) and go to HOLD.
//     HOLD:  valid_out=1. code_out and valid_out stay stable while !ready_in.
//            On accept, if pending_nxt != 0, load the next pick (back-to-back, no bubble).
//            On accept, if pending_nxt == 0, go to EMPTY.
//   pick(): HIGH_FIRST=1 -> index of the highest set bit; 0 -> index of the lowest set bit.
//     Priority is re-evaluated only at load. A higher request arriving during HOLD does not
//     pre-empt the presented code.
//   Latency: req_in high at cycle t with the FSM in EMPTY -> valid_out=1 at cycle t+1.
//   Simultaneous accept of line i and req_in[i]: the bit stays set as a new event, with no
//     overflow. The same index can be re-presented the next cycle.
//   Overflow: req_in[i] & pending[i] & ~(accept & code_out==i) -> overflow_out=1 for the next
//     cycle only. The events are merged into one. Multiple lines in one cycle give one pulse.
//   pending_out equals pending. The presented bit stays set until accepted.
//   All outputs are registered; there is no combinational path from req_in or ready_in to any output.
// STRUCTURE
//   Shared include encoder_defs.vh: N_IN, CODE_W, state encodings ST_EMPTY=1'b0, ST_HOLD=1'b1.
//   Sub-module prio_enc_8x3 (combinational): in[7:0], HIGH_FIRST -> idx[2:0], any.
//     Instantiated once on pending_nxt.
//   Top level: pending register, 2-state FSM, output register, overflow detect.
// TESTING
//   1 Reset: assert rst mid-HOLD with pending=8'hA5 -> pending_out=0, valid_out=0, code_out=0
//     immediately; no output after release.
//   2 Single: req_in=8'h10 for 1 cycle, ready_in=1 -> next cycle code_out=4, valid_out=1;
//     following cycle valid_out=0.
//   3 Priority with stall: req_in=8'h81 in one cycle, ready_in=0 for 3 cycles -> code_out=7
//     held stable; ready_in=1 -> code_out=0 next cycle, then empty.
//     With HIGH_FIRST=0 the order is 0 then 7.
//   4 Overflow: req_in=8'h04, then req_in=8'h04 again with ready_in=0 -> overflow_out pulses 1
//     cycle; exactly one code 2 is delivered.
//   5 Accept/re-request collision: presenting code 3, ready_in=1 and req_in=8'h08 in the same
//     cycle -> no overflow; code 3 is presented again next cycle.
//   6 Back-to-back: req_in=8'hFF once, ready_in=1 -> codes 7,6,...,0 on 8 consecutive cycles
//     with no bubble; then valid_out=0.

Source files
------------

// File: rtl/event_encoder_8x3_pkg.sv
// Shared widths and FSM encoding for the 8-line event encoder.
package event_encoder_8x3_pkg;

  localparam int N_IN   = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } enc_state_e;

endpackage

// File: rtl/event_encoder_8x3_prio.sv
// Combinational 8-to-3 priority encoder; HIGH_FIRST selects which end wins.
module prio_enc_8x3
  import event_encoder_8x3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N_IN-1:0]   vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    if (HIGH_FIRST) begin
      for (int i = 0; i < N_IN; i++) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/event_encoder_8x3.sv
// Collects request events as pending bits and presents them one at a time as a
// 3-bit code over a valid/ready handshake; flags events merged into a pending bit.
module event_encoder_8x3
  import event_encoder_8x3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req_in,
  output logic [CODE_W-1:0] code_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [N_IN-1:0]   pending_out,
  output logic              overflow_out,
  output enc_state_e        state_out
);

  // Handshake: code_out is transferred on any rising edge where valid_out and
  // ready_in are both high; while valid_out=1 and ready_in=0, code_out holds.

  enc_state_e        state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic [N_IN-1:0]   clr_mask;
  logic [CODE_W-1:0] pick_idx;
  logic              pick_any;

  assign accept = (state_q == ST_HOLD) && ready_in;

  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[code_q] = 1'b1;
  end

  // A request on the line being accepted this cycle is a fresh event, not a merge.
  assign pending_d  = (pending_q & ~clr_mask) | req_in;
  assign overflow_d = |(req_in & pending_q & ~clr_mask);

  prio_enc_8x3 #(.HIGH_FIRST(HIGH_FIRST)) u_prio (
    .vec_i (pending_d),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (pick_any) begin
          state_d = ST_HOLD;
          code_d  = pick_idx;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (pick_any) begin
            code_d = pick_idx;
          end else begin
            state_d = ST_EMPTY;
            code_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      pending_q  <= '0;
      code_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
    end
  end

  assign code_out     = code_q;
  assign valid_out    = (state_q == ST_HOLD);
  assign pending_out  = pending_q;
  assign overflow_out = overflow_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_event_encoder_8x3.sv
// Directed bench for event_encoder_8x3: high-first DUT plus a low-first copy
// for the priority-order scenario.
module tb_event_encoder_8x3;
  import event_encoder_8x3_pkg::*;

  logic              clk;
  logic              rst;
  logic [N_IN-1:0]   req_in;
  logic              ready_in;
  logic [CODE_W-1:0] code_out, code_lo;
  logic              valid_out, valid_lo;
  logic [N_IN-1:0]   pending_out, pending_lo;
  logic              overflow_out, overflow_lo;
  enc_state_e        state_out, state_lo;

  int n_pass  = 0;
  int n_total = 0;

  event_encoder_8x3 #(.HIGH_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .code_out     (code_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .pending_out  (pending_out),
    .overflow_out (overflow_out),
    .state_out    (state_out)
  );

  event_encoder_8x3 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .code_out     (code_lo),
    .valid_out    (valid_lo),
    .ready_in     (ready_in),
    .pending_out  (pending_lo),
    .overflow_out (overflow_lo),
    .state_out    (state_lo)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = '0; ready_in = 1'b0;
    step();
    n_total++;
    if ({valid_out, code_out, pending_out, overflow_out} !== 13'h0)
      $display("FAIL reset_init: valid=%0b code=%0d pending=%h ovf=%0b, want all 0",
               valid_out, code_out, pending_out, overflow_out);
    else n_pass++;
    rst = 1'b0;
    step();
    req_in = 8'hA5;
    step();
    req_in = '0;
    n_total++;
    if (valid_out !== 1'b1 || code_out !== 3'd7 || pending_out !== 8'hA5)
      $display("FAIL reset_prep: valid=%0b code=%0d pending=%h, want 1 7 a5",
               valid_out, code_out, pending_out);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (pending_out !== 8'h00 || valid_out !== 1'b0 || code_out !== 3'd0 || state_out !== ST_EMPTY)
      $display("FAIL reset_async: valid=%0b code=%0d pending=%h, want 0 0 00",
               valid_out, code_out, pending_out);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    step();
    n_total++;
    if (valid_out !== 1'b0 || pending_out !== 8'h00)
      $display("FAIL reset_after: valid=%0b pending=%h, want 0 00", valid_out, pending_out);
    else n_pass++;
  endtask

  task automatic test_single();
    req_in = 8'h10; ready_in = 1'b1;
    step();
    req_in = '0;
    n_total++;
    if (valid_out !== 1'b1 || code_out !== 3'd4 || pending_out !== 8'h10)
      $display("FAIL single_present: valid=%0b code=%0d pending=%h, want 1 4 10",
               valid_out, code_out, pending_out);
    else n_pass++;
    step();
    n_total++;
    if (valid_out !== 1'b0 || code_out !== 3'd0 || pending_out !== 8'h00)
      $display("FAIL single_drain: valid=%0b code=%0d pending=%h, want 0 0 00",
               valid_out, code_out, pending_out);
    else n_pass++;
  endtask

  task automatic test_priority_stall();
    req_in = 8'h81; ready_in = 1'b0;
    step();
    req_in = '0;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (valid_out !== 1'b1 || code_out !== 3'd7 || pending_out !== 8'h81)
        $display("FAIL prio_hold[%0d]: valid=%0b code=%0d pending=%h, want 1 7 81",
                 k, valid_out, code_out, pending_out);
      else n_pass++;
      n_total++;
      if (valid_lo !== 1'b1 || code_lo !== 3'd0)
        $display("FAIL prio_lo_hold[%0d]: valid=%0b code=%0d, want 1 0", k, valid_lo, code_lo);
      else n_pass++;
      if (k < 2) step();
    end
    ready_in = 1'b1;
    step();
    n_total++;
    if (valid_out !== 1'b1 || code_out !== 3'd0 || pending_out !== 8'h01)
      $display("FAIL prio_second: valid=%0b code=%0d pending=%h, want 1 0 01",
               valid_out, code_out, pending_out);
    else n_pass++;
    n_total++;
    if (valid_lo !== 1'b1 || code_lo !== 3'd7)
      $display("FAIL prio_lo_second: valid=%0b code=%0d, want 1 7", valid_lo, code_lo);
    else n_pass++;
    step();
    n_total++;
    if (valid_out !== 1'b0 || valid_lo !== 1'b0 || pending_out !== 8'h00)
      $display("FAIL prio_empty: valid=%0b valid_lo=%0b pending=%h, want 0 0 00",
               valid_out, valid_lo, pending_out);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int delivered;
    delivered = 0;
    req_in = 8'h04; ready_in = 1'b0;
    step();
    n_total++;
    if (valid_out !== 1'b1 || code_out !== 3'd2 || overflow_out !== 1'b0)
      $display("FAIL ovf_first: valid=%0b code=%0d ovf=%0b, want 1 2 0",
               valid_out, code_out, overflow_out);
    else n_pass++;
    step();
    req_in = '0;
    n_total++;
    if (overflow_out !== 1'b1 || pending_out !== 8'h04)
      $display("FAIL ovf_pulse: ovf=%0b pending=%h, want 1 04", overflow_out, pending_out);
    else n_pass++;
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (valid_out && code_out == 3'd2) delivered++;
      step();
      if (k == 0) begin
        n_total++;
        if (overflow_out !== 1'b0)
          $display("FAIL ovf_one_cycle: ovf=%0b, want 0", overflow_out);
        else n_pass++;
      end
    end
    n_total++;
    if (delivered != 1 || valid_out !== 1'b0)
      $display("FAIL ovf_delivered: count=%0d valid=%0b, want 1 0", delivered, valid_out);
    else n_pass++;
  endtask

  task automatic test_collision();
    req_in = 8'h08; ready_in = 1'b0;
    step();
    n_total++;
    if (valid_out !== 1'b1 || code_out !== 3'd3)
      $display("FAIL coll_present: valid=%0b code=%0d, want 1 3", valid_out, code_out);
    else n_pass++;
    req_in = 8'h08; ready_in = 1'b1;
    step();
    req_in = '0;
    n_total++;
    if (overflow_out !== 1'b0 || valid_out !== 1'b1 || code_out !== 3'd3 || pending_out !== 8'h08)
      $display("FAIL coll_repeat: ovf=%0b valid=%0b code=%0d pending=%h, want 0 1 3 08",
               overflow_out, valid_out, code_out, pending_out);
    else n_pass++;
    step();
    n_total++;
    if (valid_out !== 1'b0 || pending_out !== 8'h00)
      $display("FAIL coll_drain: valid=%0b pending=%h, want 0 00", valid_out, pending_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [CODE_W-1:0] exp_q[$];
    logic [CODE_W-1:0] exp;
    for (int c = 7; c >= 0; c--) exp_q.push_back(CODE_W'(c));
    req_in = 8'hFF; ready_in = 1'b1;
    step();
    req_in = '0;
    for (int k = 0; k < 8; k++) begin
      exp = exp_q.pop_front();
      n_total++;
      if (valid_out !== 1'b1 || code_out !== exp)
        $display("FAIL b2b[%0d]: valid=%0b code=%0d, want 1 %0d", k, valid_out, code_out, exp);
      else n_pass++;
      step();
    end
    n_total++;
    if (valid_out !== 1'b0 || pending_out !== 8'h00 || state_out !== ST_EMPTY)
      $display("FAIL b2b_end: valid=%0b pending=%h, want 0 00", valid_out, pending_out);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; req_in = '0; ready_in = 1'b0;
    #1;
    test_reset();
    test_single();
    test_priority_stall();
    test_overflow();
    test_collision();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
